// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among NREQ
// writeback sources, with one registered output stage driving RegWrite/A3/WD3.
module regfile_write_arbiter #(
    parameter  int NREQ = 3,
    parameter  int DW   = 32,
    parameter  int AW   = 5,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 RegWrite,
    output logic [AW-1:0]        A3,
    output logic [DW-1:0]        WD3,
    output logic [GW-1:0]        grant_id,
    output logic [15:0]          wr_count
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [GW-1:0] id;
    } wb_t;

    logic [AW-1:0] addr_a [NREQ];
    logic [DW-1:0] data_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = req_addr[g*AW +: AW];
        assign data_a[g] = req_data[g*DW +: DW];
    end

    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] win;
    logic          found;
    logic          xfer;
    wb_t           out_q, out_d;
    logic [15:0]   wr_count_q, wr_count_d;

    // Search from rr_ptr upward, wrapping; the first pending requester wins.
    always_comb begin
        logic [GW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = GW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Reset gates ready combinationally so nothing is granted while RST_N is low.
    assign xfer      = found && !stall && RST_N;
    assign req_ready = xfer ? (NREQ'(1) << win) : '0;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        out_d      = out_q;
        out_d.we   = 1'b0;
        wr_count_d = wr_count_q;
        if (xfer) begin
            rr_ptr_d   = (win == GW'(NREQ-1)) ? '0 : win + 1'b1;
            out_d.addr = addr_a[win];
            out_d.data = data_a[win];
            out_d.id   = win;
            // Register 0 is hardwired: accept the transfer but never write it.
            out_d.we   = |addr_a[win];
            if ((|addr_a[win]) && !(&wr_count_q))
                wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_q   <= '0;
            out_q      <= '0;
            wr_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            out_q      <= out_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign RegWrite = out_q.we;
    assign A3       = out_q.addr;
    assign WD3      = out_q.data;
    assign grant_id = out_q.id;
    assign wr_count = wr_count_q;

endmodule
